// File: rtl/openram_bist_controller_if.sv
// SRAM-side bus of the March-test sequencer: shared port-0/port-1 control,
// write data and per-macro chip selects out, captured read data back in.
interface openram_bist_controller_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4,
  parameter int NUM_CHIPS   = 16
);
  logic [ADDR_WIDTH-1:0]  addr0;
  logic [DATA_WIDTH-1:0]  din0;
  logic                   web0;
  logic [WMASK_WIDTH-1:0] wmask0;
  logic [NUM_CHIPS-1:0]   csb0;
  logic [ADDR_WIDTH-1:0]  addr1;
  logic [NUM_CHIPS-1:0]   csb1;
  logic [DATA_WIDTH-1:0]  rdata0;
  logic [DATA_WIDTH-1:0]  rdata1;

  modport master (
    output addr0, din0, web0, wmask0, csb0, addr1, csb1,
    input  rdata0, rdata1
  );

  modport slave (
    input  addr0, din0, web0, wmask0, csb0, addr1, csb1,
    output rdata0, rdata1
  );
endinterface

// File: rtl/openram_bist_controller.sv
// March C- BIST sequencer for one OpenRAM macro. Issues one access per cycle
// with registered bus outputs, tracks outstanding reads in a READ_LATENCY-deep
// pipeline and compares the captured read data against the expected value.
module openram_bist_controller #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int WMASK_WIDTH  = 4,
  parameter int NUM_CHIPS    = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      abort,
  input  logic [3:0]                chip_sel,
  input  logic [ADDR_WIDTH-1:0]     addr_max,
  input  logic [DATA_WIDTH-1:0]     pattern,
  input  logic                      dual_port,
  openram_bist_controller_if.master sram,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ADDR_WIDTH-1:0]     fail_addr,
  output logic [DATA_WIDTH-1:0]     fail_data,
  output logic [7:0]                fail_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic                  v;
    logic                  port;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] expd;
  } rd_t;

  localparam logic [ADDR_WIDTH-1:0]   A_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NUM_CHIPS-1:0]    SEL_ONE   = {{(NUM_CHIPS-1){1'b0}}, 1'b1};
  // every stage except the compare stage
  localparam logic [READ_LATENCY-1:0] PEND_MASK = {READ_LATENCY{1'b1}} >> 1;

  state_t                  st, st_n;
  logic [ADDR_WIDTH-1:0]   a, a_n, max_q, max_n;
  logic                    ph, ph_n;
  logic [3:0]              sel_q, sel_n;
  logic [DATA_WIDTH-1:0]   pat_q, pat_n;
  logic                    dp_q, dp_n;
  logic                    clear, flush;
  logic                    is_op, is_wr, is_rd, port1;
  logic [DATA_WIDTH-1:0]   wval, rexp;
  logic [NUM_CHIPS-1:0]    sel_oh;
  logic                    op_rd, op_port;
  logic [DATA_WIDTH-1:0]   op_exp;

  rd_t                     rd_pipe [READ_LATENCY];
  rd_t                     rd_in, rd_tail;
  logic [READ_LATENCY-1:0] pipe_v;
  logic [DATA_WIDTH-1:0]   cmp_data;
  logic                    miss;

  logic [ADDR_WIDTH-1:0]   addr0_n, addr1_n, fa_n;
  logic [DATA_WIDTH-1:0]   din0_n, fd_n;
  logic                    web0_n, busy_n, done_n, pass_n;
  logic [WMASK_WIDTH-1:0]  wmask0_n;
  logic [NUM_CHIPS-1:0]    csb0_n, csb1_n;
  logic [7:0]              fc_n;

  assign rd_in   = '{v: op_rd, port: op_port, addr: a, expd: op_exp};
  assign rd_tail = rd_pipe[READ_LATENCY-1];

  for (genvar g = 0; g < READ_LATENCY; g++) begin : g_pipe
    if (g == 0) begin : g_head
      // Head stage captures the read issued during the current cycle.
      always_ff @(posedge clk) begin
        if (!resetn || flush) rd_pipe[g] <= '0;
        else                  rd_pipe[g] <= rd_in;
      end
    end else begin : g_tail
      // Later stages age outstanding reads by one cycle.
      always_ff @(posedge clk) begin
        if (!resetn || flush) rd_pipe[g] <= '0;
        else                  rd_pipe[g] <= rd_pipe[g-1];
      end
    end
    assign pipe_v[g] = rd_pipe[g].v;
  end

  // Next element/address/phase, next bus access and compare bookkeeping.
  // Outputs are computed from the next state so the access is registered
  // on the same edge that enters it.
  always_comb begin
    st_n  = st;
    a_n   = a;
    ph_n  = ph;
    sel_n = sel_q;
    max_n = max_q;
    pat_n = pat_q;
    dp_n  = dp_q;
    clear = 1'b0;
    flush = 1'b0;

    case (st)
      S_IDLE, S_DONE: begin
        if (start) begin
          st_n  = S_M0;
          a_n   = '0;
          ph_n  = 1'b0;
          sel_n = chip_sel;
          max_n = addr_max;
          pat_n = pattern;
          dp_n  = dual_port;
          clear = 1'b1;
        end
      end
      default: begin
        if (abort) begin
          st_n  = S_IDLE;
          flush = 1'b1;
        end else begin
          case (st)
            S_M0: begin
              if (a == max_q) begin
                st_n = S_M1;
                a_n  = '0;
              end else begin
                a_n = a + A_ONE;
              end
            end
            S_M1, S_M2: begin
              ph_n = ~ph;
              if (ph) begin
                if (a != max_q) begin
                  a_n = a + A_ONE;
                end else if (st == S_M1) begin
                  st_n = S_M2;
                  a_n  = '0;
                end else begin
                  st_n = S_M3;
                  a_n  = max_q;
                end
              end
            end
            S_M3, S_M4: begin
              ph_n = ~ph;
              if (ph) begin
                if (a != '0) begin
                  a_n = a - A_ONE;
                end else begin
                  st_n = (st == S_M3) ? S_M4 : S_M5;
                  a_n  = max_q;
                end
              end
            end
            S_M5: begin
              if (a != '0) a_n = a - A_ONE;
              else         st_n = S_DRAIN;
            end
            S_DRAIN: begin
              // the tail entry is compared on this same edge
              if (!(|(pipe_v & PEND_MASK))) st_n = S_DONE;
            end
            default: st_n = S_IDLE;
          endcase
        end
      end
    endcase

    is_op  = st_n inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5};
    is_wr  = (st_n == S_M0) || (ph_n && (st_n inside {S_M1, S_M2, S_M3, S_M4}));
    is_rd  = is_op && !is_wr;
    port1  = (st_n == S_M5) && dp_n;
    wval   = (st_n inside {S_M1, S_M3}) ? ~pat_n : pat_n;
    rexp   = (st_n inside {S_M2, S_M4}) ? ~pat_n : pat_n;
    sel_oh = SEL_ONE << sel_n;

    csb0_n   = (is_op && !port1) ? ~sel_oh : '1;
    csb1_n   = (is_rd && port1)  ? ~sel_oh : '1;
    addr0_n  = (is_op && !port1) ? a_n : sram.addr0;
    addr1_n  = (is_rd && port1)  ? a_n : sram.addr1;
    web0_n   = !is_wr;
    din0_n   = is_wr ? wval : sram.din0;
    wmask0_n = is_wr ? '1 : sram.wmask0;

    cmp_data = rd_tail.port ? sram.rdata1 : sram.rdata0;
    miss     = rd_tail.v && !flush && (cmp_data != rd_tail.expd);
    fa_n     = fail_addr;
    fd_n     = fail_data;
    fc_n     = fail_count;
    if (clear) begin
      fa_n = '0;
      fd_n = '0;
      fc_n = '0;
    end else if (miss) begin
      if (fail_count == 8'd0) begin
        fa_n = rd_tail.addr;
        fd_n = cmp_data;
      end
      if (fail_count != 8'hFF) fc_n = fail_count + 8'd1;
    end

    busy_n = is_op || (st_n == S_DRAIN);
    done_n = (st_n == S_DONE);
    pass_n = done_n && (fc_n == 8'd0);
  end

  // State, latched test setup, registered bus outputs and status.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st          <= S_IDLE;
      a           <= '0;
      ph          <= 1'b0;
      sel_q       <= '0;
      max_q       <= '0;
      pat_q       <= '0;
      dp_q        <= 1'b0;
      op_rd       <= 1'b0;
      op_port     <= 1'b0;
      op_exp      <= '0;
      sram.addr0  <= '0;
      sram.addr1  <= '0;
      sram.din0   <= '0;
      sram.web0   <= 1'b1;
      sram.wmask0 <= '0;
      sram.csb0   <= '1;
      sram.csb1   <= '1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
      fail_count  <= '0;
    end else begin
      st          <= st_n;
      a           <= a_n;
      ph          <= ph_n;
      sel_q       <= sel_n;
      max_q       <= max_n;
      pat_q       <= pat_n;
      dp_q        <= dp_n;
      op_rd       <= is_rd;
      op_port     <= port1;
      op_exp      <= rexp;
      sram.addr0  <= addr0_n;
      sram.addr1  <= addr1_n;
      sram.din0   <= din0_n;
      sram.web0   <= web0_n;
      sram.wmask0 <= wmask0_n;
      sram.csb0   <= csb0_n;
      sram.csb1   <= csb1_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      fail_addr   <= fa_n;
      fail_data   <= fd_n;
      fail_count  <= fc_n;
    end
  end

endmodule

// File: tb/tb_openram_bist_controller.sv
// Directed bench for openram_bist_controller with a two-stage SRAM model
// (array read + capture register) and an access log sampled on negedge.
module tb_openram_bist_controller;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int NC = 16;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          dual_port = 1'b0;
  logic [3:0]    chip_sel = 4'd3;
  logic [AW-1:0] addr_max = '0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [7:0]    fail_count;

  int n_cmp = 0;
  int n_bad = 0;

  openram_bist_controller_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .NUM_CHIPS(NC)
  ) bus ();

  openram_bist_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .NUM_CHIPS(NC),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .chip_sel(chip_sel), .addr_max(addr_max), .pattern(pattern),
    .dual_port(dual_port), .sram(bus), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // SRAM model of the selected macro; optional bit-5 stuck-at-0 at address 2.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] dout0 = '0;
  logic [DW-1:0] dout1 = '0;
  logic [DW-1:0] wr_val;
  logic          fault_en = 1'b0;

  always @(posedge clk) begin
    if (!bus.csb0[chip_sel]) begin
      if (!bus.web0) begin
        wr_val = mem[bus.addr0[3:0]];
        for (int b = 0; b < MW; b++)
          if (bus.wmask0[b]) wr_val[b*8 +: 8] = bus.din0[b*8 +: 8];
        if (fault_en && bus.addr0 == 16'd2) wr_val[5] = 1'b0;
        mem[bus.addr0[3:0]] <= wr_val;
      end else begin
        dout0 <= mem[bus.addr0[3:0]];
      end
    end
    if (!bus.csb1[chip_sel]) dout1 <= mem[bus.addr1[3:0]];
    bus.rdata0 <= dout0;
    bus.rdata1 <= dout1;
  end

  // Access log: one entry per cycle with any chip select low.
  typedef struct packed {
    logic          p1;
    logic          wr;
    logic          bad;
    logic [AW-1:0] a;
  } op_t;
  op_t           log_q[$];
  op_t           o;
  logic [NC-1:0] sel_mask;
  assign sel_mask = ~(16'h0001 << chip_sel);

  always @(negedge clk) begin
    if (bus.csb0 != '1 || bus.csb1 != '1) begin
      o.p1  = (bus.csb1 != '1);
      o.wr  = (bus.csb0 != '1) && !bus.web0;
      o.a   = o.p1 ? bus.addr1 : bus.addr0;
      o.bad = ((bus.csb0 != '1) && (bus.csb0 != sel_mask)) ||
              ((bus.csb1 != '1) && (bus.csb1 != sel_mask)) ||
              ((bus.csb0 != '1) && (bus.csb1 != '1));
      log_q.push_back(o);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string t);
    check({t, "_addr0"}, bus.addr0, 0);
    check({t, "_addr1"}, bus.addr1, 0);
    check({t, "_din0"}, bus.din0, 0);
    check({t, "_web0_wmask0"}, {bus.web0, bus.wmask0}, 5'b1_0000);
    check({t, "_csb0"}, bus.csb0, 16'hFFFF);
    check({t, "_csb1"}, bus.csb1, 16'hFFFF);
    check({t, "_busy_done_pass"}, {busy, done, pass}, 3'b000);
    check({t, "_fail_addr"}, fail_addr, 0);
    check({t, "_fail_data"}, fail_data, 0);
    check({t, "_fail_count"}, fail_count, 0);
  endtask

  // Pulses start; returns #1 after the edge E that samples it.
  task automatic kick();
    log_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after E until done, bounded.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic scan_log(output int nw, output int np1, output int nbad);
    nw = 0; np1 = 0; nbad = 0;
    foreach (log_q[i]) begin
      nw   += int'(log_q[i].wr);
      np1  += int'(log_q[i].p1);
      nbad += int'(log_q[i].bad);
    end
  endtask

  initial begin
    int            lat, nw, np1, nbad;
    logic [9:0]    wrs;
    logic [AW-1:0] aor;
    logic [3:0]    tail_p1;
    logic [15:0]   tail_a;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    resetn = 1'b1;

    // fault-free run, N=4
    chip_sel = 4'd3; addr_max = 16'd3; pattern = 32'hA5A5_A5A5; dual_port = 1'b0;
    kick();
    check("t1_busy_at_E", busy, 1);
    check("t1_first_csb0", bus.csb0, 16'hFFF7);
    check("t1_first_wr", {bus.web0, bus.wmask0, bus.addr0}, {1'b0, 4'hF, 16'h0000});
    check("t1_first_din", bus.din0, 32'hA5A5_A5A5);
    wait_done(0, lat);
    check("t1_latency", lat, 42);
    check("t1_status", {busy, done, pass}, 3'b011);
    check("t1_fail_count", fail_count, 0);
    scan_log(nw, np1, nbad);
    check("t1_accesses", log_q.size(), 40);
    check("t1_writes", nw, 20);
    check("t1_port1_and_bad_csb", {np1[7:0], nbad[7:0]}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_holds", {done, pass}, 2'b11);

    // stuck-at-0 on bit 5 of address 2, P=0: ~P reads in M2 and M4 see FFFFFFDF
    fault_en = 1'b1; pattern = 32'h0;
    kick();
    check("t2_done_cleared", done, 0);
    wait_done(0, lat);
    fault_en = 1'b0;
    check("t2_latency", lat, 42);
    check("t2_pass", {done, pass}, 2'b10);
    check("t2_fail_addr", fail_addr, 2);
    check("t2_fail_data", fail_data, 32'hFFFF_FFDF);
    check("t2_fail_count", fail_count, 2);

    // N=1
    addr_max = 16'd0; pattern = 32'h1234_5678;
    kick();
    check("t3_fail_cleared", {fail_count, fail_addr, fail_data[7:0], done}, 0);
    wait_done(0, lat);
    check("t3_latency", lat, 12);
    check("t3_pass", {done, pass}, 2'b11);
    check("t3_accesses", log_q.size(), 10);
    wrs = '0; aor = '0;
    foreach (log_q[i]) if (i < 10) begin
      wrs[i] = log_q[i].wr;
      aor    = aor | log_q[i].a;
    end
    check("t3_wr_sequence", wrs, 10'b01_0101_0101);
    check("t3_addr_all_zero", aor, 0);

    // dual-port final element
    addr_max = 16'd3; pattern = 32'h0F0F_0F0F; dual_port = 1'b1;
    kick();
    wait_done(0, lat);
    dual_port = 1'b0;
    check("t4_latency", lat, 42);
    check("t4_pass", {done, pass}, 2'b11);
    check("t4_accesses", log_q.size(), 40);
    scan_log(nw, np1, nbad);
    check("t4_port1_count_bad", {np1[7:0], nbad[7:0]}, {8'd4, 8'd0});
    tail_p1 = '0; tail_a = '0;
    if (log_q.size() == 40) begin
      tail_p1 = {log_q[36].p1, log_q[37].p1, log_q[38].p1, log_q[39].p1};
      tail_a  = {log_q[36].a[3:0], log_q[37].a[3:0], log_q[38].a[3:0], log_q[39].a[3:0]};
    end
    check("t4_tail_port1", tail_p1, 4'b1111);
    check("t4_tail_addr1", tail_a, 16'h3210);

    // abort two cycles into M2 (M2 occupies cycles 12..19 for N=4)
    pattern = 32'hDEAD_BEEF;
    kick();
    repeat (13) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("t5_abort_status", {busy, done, pass}, 3'b000);
    check("t5_abort_csb", {bus.csb0, bus.csb1}, 32'hFFFF_FFFF);
    check("t5_abort_accesses", log_q.size(), 14);
    repeat (4) @(posedge clk);
    #1;
    check("t5_idle_after_abort", {busy, done, fail_count}, 0);
    kick();
    wait_done(0, lat);
    check("t5_rerun_latency", lat, 42);
    check("t5_rerun_pass", {done, pass}, 2'b11);

    // start and setup changes while busy are ignored
    pattern = 32'h3C3C_C3C3;
    kick();
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; addr_max = 16'd0; pattern = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(6, lat);
    check("t6_ignored_start_latency", lat, 42);
    check("t6_pass", {done, pass}, 2'b11);

    // reset during M3 (cycles 20..27 for N=4)
    addr_max = 16'd3;
    kick();
    repeat (22) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_reset("mid");
    @(negedge clk);
    resetn = 1'b1;
    addr_max = 16'd1;
    kick();
    wait_done(0, lat);
    check("t7_after_reset_latency", lat, 22);
    check("t7_after_reset_pass", {done, pass, fail_count}, {2'b11, 8'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
